xpb_window_accum: RTL and testbench

//  Sequential reduction accumulator downstream of the per-window XPB lookup ROMs
//  (5-bit code in, 1024-bit precomputed x*2^k mod N out). Takes the overflow bits
//  of a squared product, walks them one 5-bit window per cycle, and drives the
//  ROM bank (window index + code). It adds each returned 1024-bit constant onto a

---
 rtl/xpb_window_accum.sv | 140 ++++++++++++++
 tb/tb_xpb_window_accum.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/xpb_window_accum.sv
// -----------------------------------------------------------------------------
// xpb_window_accum
//
// Sequential reduction accumulator that sits behind the bank of per-window XPB
// lookup ROMs. The overflow bits of a squared product arrive on upper_in, one
// WIN_W-bit window per ROM. This block walks the windows one per cycle. It
// drives the ROM bank with the window number (lut_idx) and that window's code
// (lut_code). It then adds the returned DATA_W-bit constant (lut_data) onto the
// lower product part (base_in). The widened sum goes to the final modular
// correction stage.
//
// Ports
//   clk        clock
//   reset      synchronous, active-high reset
//   start      request; accepted only while busy is low
//   upper_in   NUM_WIN windows of WIN_W bits; window i = upper_in[i*WIN_W +: WIN_W]
//   base_in    start value of the sum (lower product part)
//   busy       high from the accepting edge through the valid_out cycle
//   lut_idx    ROM select (window number); 0 outside RUN
//   lut_code   ROM address for the selected window; 0 outside RUN
//   lut_data   ROM output, combinational from lut_idx/lut_code
//   valid_out  one-cycle pulse; sum_out is final in that cycle
//   sum_out    base_in + all looked-up constants; held until the next result
//
// Timing: the start cycle, NUM_WIN RUN cycles and the DONE cycle add up to
// NUM_WIN+2 cycles. valid_out is high in the DONE cycle. A new request can be
// accepted in the cycle right after DONE.
// -----------------------------------------------------------------------------
module xpb_window_accum #(
    parameter int NUM_WIN = 8,
    parameter int WIN_W   = 5,
    parameter int DATA_W  = 1024,
    parameter int EXT_W   = 4,
    localparam int IDX_W  = (NUM_WIN > 1) ? $clog2(NUM_WIN) : 1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic [NUM_WIN*WIN_W-1:0]   upper_in,
    input  logic [DATA_W-1:0]          base_in,
    output logic                       busy,
    output logic [IDX_W-1:0]           lut_idx,
    output logic [WIN_W-1:0]           lut_code,
    input  logic [DATA_W-1:0]          lut_data,
    output logic                       valid_out,
    output logic [DATA_W+EXT_W-1:0]    sum_out
);

    localparam int SUM_W = DATA_W + EXT_W;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                     state_reg;
    logic [NUM_WIN*WIN_W-1:0]   window_reg;
    logic [IDX_W-1:0]           idx_reg;
    logic [SUM_W-1:0]           acc_reg;
    logic [SUM_W-1:0]           sum_reg;
    logic                       valid_reg;

    logic [WIN_W-1:0]           window_vec [NUM_WIN];
    logic [SUM_W-1:0]           acc_next;
    logic                       in_run;
    logic                       last_win;
    logic                       accept;

    // Unpacked view of the captured windows, so the current one can be picked
    // by idx_reg.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_WIN; gi++) begin : g_win
            assign window_vec[gi] = window_reg[gi*WIN_W +: WIN_W];
        end
    endgenerate

    assign in_run   = (state_reg == RUN);
    assign last_win = (idx_reg == IDX_W'(NUM_WIN - 1));
    assign accept   = (state_reg == IDLE) && start;

    // lut_data is only consumed on RUN edges. Outside RUN, whatever the ROM
    // bank returns (including X) never reaches a register.
    assign acc_next = acc_reg + {{EXT_W{1'b0}}, lut_data};

    // ROM addressing comes straight from registers. It is forced to zero
    // outside RUN, so an idle ROM bank sees a quiet address.
    assign lut_idx  = in_run ? idx_reg : '0;
    assign lut_code = in_run ? window_vec[idx_reg] : '0;

    assign busy      = (state_reg != IDLE);
    assign valid_out = valid_reg;
    assign sum_out   = sum_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg  <= IDLE;
            window_reg <= '0;
            idx_reg    <= '0;
            acc_reg    <= '0;
            sum_reg    <= '0;
            valid_reg  <= 1'b0;
        end else begin
            valid_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        // Capture everything now. Later changes on upper_in
                        // or base_in do not affect this run.
                        window_reg <= upper_in;
                        acc_reg    <= {{EXT_W{1'b0}}, base_in};
                        idx_reg    <= '0;
                        state_reg  <= RUN;
                    end
                end
                RUN: begin
                    // A zero code still takes its cycle; the ROM returns 0.
                    acc_reg <= acc_next;
                    idx_reg <= idx_reg + 1'b1;
                    if (last_win) begin
                        // The final sum is registered on the same edge that
                        // enters DONE, so valid_out coincides with the DONE cycle.
                        sum_reg   <= acc_next;
                        valid_reg <= 1'b1;
                        state_reg <= DONE;
                    end
                end
                DONE: begin
                    // A start seen in this cycle is dropped, not queued.
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_xpb_window_accum.sv
module tb_xpb_window_accum;

    localparam int NUM_WIN = 8;
    localparam int WIN_W   = 5;
    localparam int DATA_W  = 1024;
    localparam int EXT_W   = 4;
    localparam int IDX_W   = 3;
    localparam int UW      = NUM_WIN * WIN_W;
    localparam int SW      = DATA_W + EXT_W;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic [UW-1:0]     upper_in;
    logic [DATA_W-1:0] base_in;
    logic              busy;
    logic [IDX_W-1:0]  lut_idx;
    logic [WIN_W-1:0]  lut_code;
    logic [DATA_W-1:0] lut_data;
    logic              valid_out;
    logic [SW-1:0]     sum_out;

    bit rom_all_ones;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    xpb_window_accum #(
        .NUM_WIN(NUM_WIN), .WIN_W(WIN_W), .DATA_W(DATA_W), .EXT_W(EXT_W)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .upper_in(upper_in),
        .base_in(base_in), .busy(busy), .lut_idx(lut_idx), .lut_code(lut_code),
        .lut_data(lut_data), .valid_out(valid_out), .sum_out(sum_out)
    );

    // ROM bank model: (window number + 1) * code, or all ones for the
    // saturation case.
    always_comb begin
        lut_data = '0;
        if (rom_all_ones)
            lut_data = '1;
        else
            lut_data = DATA_W'((32'(lut_idx) + 32'd1) * 32'(lut_code));
    end

    typedef struct {
        string           name;
        logic [UW-1:0]   upper;
        logic [DATA_W-1:0] base;
        bit              all_ones;
        logic [SW-1:0]   exp_sum;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input logic [SW-1:0] act, input logic [SW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=top:%h low:%h required=top:%h low:%h",
                     name, act[SW-1:SW-36], act[63:0], exp[SW-1:SW-36], exp[63:0]);
        end
    endtask

    // One request: pulse start, scramble the inputs after acceptance, follow
    // the RUN walk and check latency, addressing and the result.
    task automatic run_one(input string name, input logic [UW-1:0] up,
                           input logic [DATA_W-1:0] base, input bit ones,
                           input logic [SW-1:0] exp_sum);
        int cyc;
        @(negedge clk);
        upper_in = up;
        base_in = base;
        rom_all_ones = ones;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        upper_in = {$urandom, $urandom};
        base_in = {32{$urandom}};
        cyc = 1;
        while (!valid_out && cyc < 20) begin
            chk({name, " busy"}, SW'(busy), SW'(1));
            if (cyc <= NUM_WIN) begin
                chk({name, " lut_idx"}, SW'(lut_idx), SW'(cyc - 1));
                chk({name, " lut_code"}, SW'(lut_code), SW'(up[(cyc-1)*WIN_W +: WIN_W]));
            end
            @(negedge clk);
            cyc++;
        end
        chk({name, " latency"}, SW'(cyc), SW'(NUM_WIN + 1));
        chk({name, " sum_out"}, sum_out, exp_sum);
        chk({name, " busy_at_valid"}, SW'(busy), SW'(1));
        $display("run %s cycles=%0d sum_low=%h", name, cyc + 1, sum_out[31:0]);
        @(negedge clk);
        chk({name, " valid_drop"}, SW'(valid_out), SW'(0));
        chk({name, " busy_drop"}, SW'(busy), SW'(0));
        chk({name, " sum_hold"}, sum_out, exp_sum);
    endtask

    initial begin
        logic [SW-1:0] ones_sum;
        logic [SW-1:0] exp;
        logic [UW-1:0] up;
        logic [DATA_W-1:0] base;
        int pulses;
        int first_pulse;
        int last_pulse;

        // 9*(2^1024-1) = 8*2^1024 + (2^1024 - 9)
        ones_sum = '0;
        ones_sum[SW-1:DATA_W] = 4'h8;
        ones_sum[DATA_W-1:0] = {DATA_W{1'b1}} - DATA_W'(8);

        vecs[0] = '{"zero_windows", '0, DATA_W'(5), 1'b0, SW'(5)};
        vecs[1] = '{"all_1f", {UW{1'b1}}, '0, 1'b0, SW'(1116)};
        vecs[2] = '{"saturate", {UW{1'b1}}, {DATA_W{1'b1}}, 1'b1, ones_sum};
        vecs[3] = '{"ramp", {5'd8, 5'd7, 5'd6, 5'd5, 5'd4, 5'd3, 5'd2, 5'd1},
                    DATA_W'(100), 1'b0, SW'(304)};
        vecs[4] = '{"alternate", {5'd0, 5'h1F, 5'd0, 5'h1F, 5'd0, 5'h1F, 5'd0, 5'h1F},
                    DATA_W'(7), 1'b0, SW'(503)};
        vecs[5] = '{"last_only", {5'd3, 35'd0}, '0, 1'b0, SW'(24)};

        reset = 1'b1;
        start = 1'b0;
        upper_in = '0;
        base_in = '0;
        rom_all_ones = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset busy", SW'(busy), SW'(0));
        chk("reset valid", SW'(valid_out), SW'(0));
        chk("reset sum", sum_out, '0);
        chk("reset lut_idx", SW'(lut_idx), SW'(0));
        chk("reset lut_code", SW'(lut_code), SW'(0));

        // start together with reset: reset wins
        upper_in = {UW{1'b1}};
        start = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        start = 1'b0;
        chk("reset_vs_start busy", SW'(busy), SW'(0));
        @(negedge clk);
        chk("reset_vs_start idle", SW'(busy), SW'(0));
        chk("reset_vs_start valid", SW'(valid_out), SW'(0));

        for (int i = 0; i < 6; i++)
            run_one(vecs[i].name, vecs[i].upper, vecs[i].base, vecs[i].all_ones, vecs[i].exp_sum);

        // start held high: one accept per NUM_WIN+2 cycles
        rom_all_ones = 1'b0;
        upper_in = {UW{1'b1}};
        base_in = '0;
        start = 1'b1;
        pulses = 0;
        first_pulse = -1;
        last_pulse = -1;
        for (int i = 0; i < 45; i++) begin
            @(negedge clk);
            if (i == 29) start = 1'b0;
            if (valid_out) begin
                if (pulses > 0)
                    chk("stream spacing", SW'(i - last_pulse), SW'(NUM_WIN + 2));
                else
                    first_pulse = i;
                chk("stream sum", sum_out, SW'(1116));
                pulses++;
                last_pulse = i;
                $display("stream pulse %0d at cycle %0d", pulses, i);
            end
        end
        chk("stream pulses", SW'(pulses), SW'(3));
        chk("stream first", SW'(first_pulse), SW'(NUM_WIN));

        // reset in the middle of a run
        @(negedge clk);
        upper_in = {5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8};
        base_in = DATA_W'(9);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        chk("abort idx", SW'(lut_idx), SW'(3));
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("abort busy", SW'(busy), SW'(0));
        chk("abort valid", SW'(valid_out), SW'(0));
        chk("abort sum", sum_out, '0);
        chk("abort lut_code", SW'(lut_code), SW'(0));
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            chk("abort no_valid", SW'(valid_out), SW'(0));
        end
        $display("run abort_mid_run");
        run_one("after_abort", {UW{1'b1}}, '0, 1'b0, SW'(1116));

        // random requests against the reference sum
        for (int r = 0; r < 100; r++) begin
            up = {$urandom, $urandom};
            for (int w = 0; w < DATA_W / 32; w++)
                base[w*32 +: 32] = $urandom;
            exp = {{EXT_W{1'b0}}, base};
            for (int w = 0; w < NUM_WIN; w++)
                exp = exp + SW'((w + 1) * int'(up[w*WIN_W +: WIN_W]));
            run_one($sformatf("random%0d", r), up, base, 1'b0, exp);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
